// File: rtl/ram_arbiter.sv
// Two-port single-RAM arbiter: combinational grant, 1-cycle read return, shared rdata.
// Optional macro RAM_ARB_ROUND_ROBIN_EN selects round-robin contention; default is fixed priority to port A.
module ram_arbiter #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic              a_we,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic              a_rvalid,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic              b_we,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_data_out
);

    logic              grant_a;
    logic              grant_b;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              a_rvalid_q;
    logic              b_rvalid_q;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    // last_b = 1 means port B won the most recent grant, so A wins the next contention.
    logic last_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_b <= 1'b1;
        end else if (grant_a || grant_b) begin
            last_b <= grant_b;
        end
    end

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!reset) begin
            if (a_req && b_req) begin
                grant_a = last_b;
                grant_b = !last_b;
            end else begin
                grant_a = a_req;
                grant_b = b_req;
            end
        end
    end
`else
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!reset) begin
            grant_a = a_req;
            grant_b = b_req && !a_req;
        end
    end
`endif

    always_comb begin
        ram_addr    = addr_q;
        ram_data_in = wdata_q;
        ram_we      = 1'b0;
        if (grant_a) begin
            ram_addr    = a_addr;
            ram_data_in = a_wdata;
            ram_we      = a_we;
        end else if (grant_b) begin
            ram_addr    = b_addr;
            ram_data_in = b_wdata;
            ram_we      = b_we;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            if (grant_a || grant_b) begin
                addr_q  <= ram_addr;
                wdata_q <= ram_data_in;
            end
            a_rvalid_q <= grant_a && !a_we;
            b_rvalid_q <= grant_b && !b_we;
        end
    end

    // Masked during reset so a read granted just before reset never returns.
    assign a_rvalid = a_rvalid_q && !reset;
    assign b_rvalid = b_rvalid_q && !reset;
    assign a_ack    = grant_a;
    assign b_ack    = grant_b;
    assign rdata    = ram_data_out;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed vector table plus randomized traffic against a behavioural model.
module tb_ram_arbiter;
    localparam int AW = 15;
    localparam int DW = 8;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk;
    logic reset;
    logic a_req, a_we, a_ack, a_rvalid;
    logic b_req, b_we, b_ack, b_rvalid;
    logic [AW-1:0] a_addr, b_addr, ram_addr;
    logic [DW-1:0] a_wdata, b_wdata, rdata, ram_data_in, ram_data_out;
    logic ram_we;

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_addr(a_addr), .a_we(a_we), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rvalid(a_rvalid),
        .b_req(b_req), .b_addr(b_addr), .b_we(b_we), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rvalid(b_rvalid),
        .rdata(rdata), .ram_addr(ram_addr), .ram_data_in(ram_data_in),
        .ram_we(ram_we), .ram_data_out(ram_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          ar;
        bit          aw;
        logic [AW-1:0] aa;
        logic [DW-1:0] ad;
        bit          br;
        bit          bw;
        logic [AW-1:0] ba;
        logic [DW-1:0] bd;
        logic [1:0]  e_ack;
        bit          e_we;
        logic [AW-1:0] e_addr;
        bit          c_addr;
        logic [1:0]  e_rv;
        logic [DW-1:0] e_rd;
    } vec_t;

    logic [DW-1:0] ram     [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit            m_last_b = 1'b1;
    int            m_pend = 0;
    logic [DW-1:0] m_pend_data = '0;
    logic [AW-1:0] m_held_addr = '0;
    logic [DW-1:0] m_held_data = '0;
    bit            m_known = 1'b0;

    function automatic logic [DW-1:0] pat(int i);
        return DW'(i * 37 + (i >> 7));
    endfunction

    function automatic vec_t v(bit rst, bit ar, bit aw, logic [AW-1:0] aa, logic [DW-1:0] ad,
                               bit br, bit bw, logic [AW-1:0] ba, logic [DW-1:0] bd,
                               logic [1:0] e_ack, bit e_we, logic [AW-1:0] e_addr, bit c_addr,
                               logic [1:0] e_rv, logic [DW-1:0] e_rd);
        vec_t r;
        r.rst = rst; r.ar = ar; r.aw = aw; r.aa = aa; r.ad = ad;
        r.br = br; r.bw = bw; r.ba = ba; r.bd = bd;
        r.e_ack = e_ack; r.e_we = e_we; r.e_addr = e_addr; r.c_addr = c_addr;
        r.e_rv = e_rv; r.e_rd = e_rd;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle, checks mid-cycle, then advances the model and RAM across the edge.
    task automatic apply(vec_t t, bit use_tab);
        bit ga, gb;
        logic          c_we;
        logic [AW-1:0] c_addr;
        logic [DW-1:0] c_data, rd;
        reset = t.rst;
        a_req = t.ar; a_we = t.aw; a_addr = t.aa; a_wdata = t.ad;
        b_req = t.br; b_we = t.bw; b_addr = t.ba; b_wdata = t.bd;
        #4;
        ga = 1'b0; gb = 1'b0;
        if (!t.rst) begin
            if (t.ar && t.br) begin
                ga = RR ? m_last_b : 1'b1;
                gb = !ga;
            end else begin
                ga = t.ar;
                gb = t.br;
            end
        end
        chk("a_ack", 32'(a_ack), 32'(ga));
        chk("b_ack", 32'(b_ack), 32'(gb));
        chk("ram_we", 32'(ram_we), 32'((ga && t.aw) || (gb && t.bw)));
        if (ga) begin
            chk("ram_addr", 32'(ram_addr), 32'(t.aa));
            chk("ram_data_in", 32'(ram_data_in), 32'(t.ad));
        end else if (gb) begin
            chk("ram_addr", 32'(ram_addr), 32'(t.ba));
            chk("ram_data_in", 32'(ram_data_in), 32'(t.bd));
        end else if (m_known) begin
            chk("ram_addr_hold", 32'(ram_addr), 32'(m_held_addr));
            chk("ram_data_in_hold", 32'(ram_data_in), 32'(m_held_data));
        end
        chk("a_rvalid", 32'(a_rvalid), 32'(!t.rst && m_pend == 1));
        chk("b_rvalid", 32'(b_rvalid), 32'(!t.rst && m_pend == 2));
        if (!t.rst && m_pend != 0) chk("rdata", 32'(rdata), 32'(m_pend_data));
        if (use_tab) begin
            chk("tab_ack", 32'({a_ack, b_ack}), 32'(t.e_ack));
            chk("tab_we", 32'(ram_we), 32'(t.e_we));
            if (t.c_addr) chk("tab_addr", 32'(ram_addr), 32'(t.e_addr));
            chk("tab_rvalid", 32'({a_rvalid, b_rvalid}), 32'(t.e_rv));
            if (t.e_rv != 2'b00) chk("tab_rdata", 32'(rdata), 32'(t.e_rd));
        end
        if (t.rst) begin
            m_pend = 0; m_held_addr = '0; m_held_data = '0; m_known = 1'b1; m_last_b = 1'b1;
        end else begin
            m_pend = 0;
            if (ga) begin
                if (!t.aw) begin m_pend = 1; m_pend_data = ref_mem[t.aa]; end
                else ref_mem[t.aa] = t.ad;
                m_held_addr = t.aa; m_held_data = t.ad; m_last_b = 1'b0;
            end else if (gb) begin
                if (!t.bw) begin m_pend = 2; m_pend_data = ref_mem[t.ba]; end
                else ref_mem[t.ba] = t.bd;
                m_held_addr = t.ba; m_held_data = t.bd; m_last_b = 1'b1;
            end
        end
        c_we = ram_we; c_addr = ram_addr; c_data = ram_data_in;
        @(posedge clk);
        rd = ram[c_addr];
        if (c_we) ram[c_addr] = c_data;
        ram_data_out = rd;
        #1;
    endtask

    vec_t tab[$];
    vec_t rv;

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i] = pat(i);
            ref_mem[i] = pat(i);
        end
        ram_data_out = '0;
        reset = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;

        tab.push_back(v(1, 1,0,'h100,0,    1,0,'h200,0,   2'b00,0,'h0,0,    2'b00,0));
        tab.push_back(v(1, 1,0,'h100,0,    1,0,'h200,0,   2'b00,0,'h0,1,    2'b00,0));
        tab.push_back(v(1, 1,0,'h100,0,    1,0,'h200,0,   2'b00,0,'h0,1,    2'b00,0));
        tab.push_back(v(0, 1,1,'h1234,'hA5, 0,0,0,0,      2'b10,1,'h1234,1, 2'b00,0));
        tab.push_back(v(0, 1,0,'h1234,0,   0,0,0,0,       2'b10,0,'h1234,1, 2'b00,0));
        tab.push_back(v(0, 0,0,0,0,        0,0,0,0,       2'b00,0,'h1234,1, 2'b10,'hA5));
        tab.push_back(v(0, 0,0,0,0,        1,1,'h10,'h3C, 2'b01,1,'h10,1,   2'b00,0));
        tab.push_back(v(0, 0,0,0,0,        0,0,0,0,       2'b00,0,'h10,1,   2'b00,0));
        tab.push_back(v(0, 0,0,0,0,        0,0,0,0,       2'b00,0,'h10,1,   2'b00,0));
        tab.push_back(v(0, 1,0,'h1234,0,   1,0,'h10,0,    2'b10,0,'h1234,1, 2'b00,0));
        tab.push_back(v(0, 1,0,'h1234,0,   1,0,'h10,0,    RR ? 2'b01 : 2'b10,0,
                        RR ? 15'h10 : 15'h1234,1, 2'b10,'hA5));
        tab.push_back(v(0, 1,0,'h1234,0,   1,0,'h10,0,    2'b10,0,'h1234,1,
                        RR ? 2'b01 : 2'b10, RR ? 8'h3C : 8'hA5));
        tab.push_back(v(0, 1,0,'h1234,0,   1,0,'h10,0,    RR ? 2'b01 : 2'b10,0,
                        RR ? 15'h10 : 15'h1234,1, 2'b10,'hA5));
        tab.push_back(v(0, 0,0,0,0,        0,0,0,0,       2'b00,0, RR ? 15'h10 : 15'h1234,1,
                        RR ? 2'b01 : 2'b10, RR ? 8'h3C : 8'hA5));
        tab.push_back(v(0, 0,0,0,0,        1,0,'h10,0,    2'b01,0,'h10,1,   2'b00,0));
        tab.push_back(v(1, 1,0,'h1234,0,   1,0,'h10,0,    2'b00,0,'h10,1,   2'b00,0));
        tab.push_back(v(0, 1,0,'h1234,0,   1,0,'h10,0,    2'b10,0,'h1234,1, 2'b00,0));
        tab.push_back(v(0, 0,0,0,0,        0,0,0,0,       2'b00,0,'h1234,1, 2'b10,'hA5));

        @(posedge clk);
        #1;
        foreach (tab[i]) apply(tab[i], 1'b1);

        for (int n = 0; n < 600; n++) begin
            rv = v(0, 0,0,0,0, 0,0,0,0, 2'b00,0,0,0, 2'b00,0);
            rv.rst = ($urandom_range(0, 39) == 0);
            rv.ar  = ($urandom_range(0, 9) < 6);
            rv.aw  = $urandom_range(0, 1) == 1;
            rv.aa  = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            rv.ad  = DW'($urandom);
            rv.br  = ($urandom_range(0, 9) < 6);
            rv.bw  = $urandom_range(0, 1) == 1;
            rv.ba  = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            rv.bd  = DW'($urandom);
            apply(rv, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
